bus_fabric: RTL

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_fabric_addr_match.sv | 28 ++
 rtl/bus_fabric.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus fabric: address width, default slave map
// and the transaction state encoding.
package bus_pkg;

    localparam int unsigned AW = 32;

    localparam logic [2*AW-1:0] DEF_BASE = {32'h0000_0200, 32'h0000_0000};
    localparam logic [2*AW-1:0] DEF_MASK = {32'hFFFF_FFF0, 32'hFFFF_FF80};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        ERR
    } state_t;

endpackage

// File: rtl/bus_fabric_addr_match.sv
// Combinational address decoder: one-hot hit vector (highest matching
// index wins) plus a flag for addresses that match no slave.
module addr_match
    import bus_pkg::*;
#(
    parameter int unsigned        NSLV = 2,
    parameter logic [NSLV*AW-1:0] BASE = DEF_BASE,
    parameter logic [NSLV*AW-1:0] MASK = DEF_MASK
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] hit,
    output logic            none
);

    // Later iterations overwrite earlier ones, so the highest index wins.
    always_comb begin
        hit  = '0;
        none = 1'b1;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit    = '0;
                hit[i] = 1'b1;
                none   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: decodes a request onto one of NSLV slaves,
// waits for completion with a stall timeout, and returns a one-cycle response.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int unsigned        NSLV = 2,
    parameter int unsigned        DW   = 32,
    parameter int unsigned        TMO  = 15,
    parameter logic [NSLV*AW-1:0] BASE = DEF_BASE,
    parameter logic [NSLV*AW-1:0] MASK = DEF_MASK
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_req,
    input  logic [AW-1:0]        m_addr,
    input  logic [3:0]           m_we,
    input  logic [DW-1:0]        m_wdata,
    output logic                 m_ready,
    output logic [DW-1:0]        m_rdata,
    output logic                 m_err,
    output logic [NSLV-1:0]      s_en,
    output logic [AW-1:0]        s_addr,
    output logic [3:0]           s_we,
    output logic [DW-1:0]        s_wdata,
    input  logic [NSLV*DW-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t          state;
    state_t          state_nx;
    logic [NSLV-1:0] hit;
    logic            none;
    logic [NSLV-1:0] sel_q;
    logic [7:0]      cnt_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   sel_rdata;
    logic            sel_ready;
    logic            tmo_hit;

    addr_match #(
        .NSLV (NSLV),
        .BASE (BASE),
        .MASK (MASK)
    ) u_match (
        .addr (m_addr),
        .hit  (hit),
        .none (none)
    );

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel_q[i]) begin
                sel_rdata = s_rdata[i*DW +: DW];
                sel_ready = s_ready[i];
            end
        end
    end

    // Counter holds the number of BUSY cycles already spent; the cycle in
    // which it would reach TMO is the last one a ready may still land in.
    assign tmo_hit = (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m_req) begin
                    state_nx = none ? ERR : BUSY;
                end
            end
            BUSY: begin
                if (sel_ready) begin
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    state_nx = ERR;
                end
            end
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            s_addr  <= '0;
            s_we    <= '0;
            s_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        s_addr  <= m_addr;
                        s_we    <= m_we;
                        s_wdata <= m_wdata;
                        sel_q   <= hit;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (sel_ready) begin
                        rdata_q <= (s_we != 4'd0) ? '0 : sel_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_ready = (state == RESP) || (state == ERR);
        m_err   = (state == ERR);
        m_rdata = (state == RESP) ? rdata_q : '0;
        s_en    = (state == BUSY) ? sel_q : '0;
    end

endmodule
